// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding, default base address and the access-fault helper.
package dmem_pkg;

    localparam logic [31:0] DM_START_DEFAULT = 32'h1001_0000;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Size/alignment fault: illegal size, odd half, or unaligned word.
    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] addr_lo);
        logic fault;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = addr_lo[0];
            SZ_WORD: fault = (addr_lo != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane handling: merges store data into the stored word
// and extracts/extends the addressed lane for loads (little-endian lanes).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        load_unsigned,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store merge: only the lanes covered by the access change.
    always_comb begin
        merged_word = old_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merged_word[7:0]   = wdata[7:0];
                    2'd1:    merged_word[15:8]  = wdata[7:0];
                    2'd2:    merged_word[23:16] = wdata[7:0];
                    2'd3:    merged_word[31:24] = wdata[7:0];
                    default: merged_word        = old_word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    merged_word[31:16] = wdata[15:0];
                end else begin
                    merged_word[15:0] = wdata[15:0];
                end
            end
            SZ_WORD: merged_word = wdata;
            default: merged_word = old_word;
        endcase
    end

    // Load lane select and sign/zero extension.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (addr_lo)
            2'd0:    byte_s = old_word[7:0];
            2'd1:    byte_s = old_word[15:8];
            2'd2:    byte_s = old_word[23:16];
            2'd3:    byte_s = old_word[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        case (size)
            SZ_BYTE: load_data = load_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: load_data = load_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SZ_WORD: load_data = old_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/WAIT/RESP handshake with configurable wait
// states over word storage. Define DMEM_RANGE_CHECK_EN to fault out-of-range addresses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] DM_START    = DM_START_DEFAULT,
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

    dmem_state_t state_r, state_nxt_s;
    logic [3:0]  wait_cnt_r, wait_cnt_nxt_s;
    logic        accept_s, enter_resp_s;

    logic        cap_we_r, cap_unsigned_r;
    logic [31:0] cap_addr_r, cap_wdata_r;
    logic [1:0]  cap_size_r;

    logic        op_we_s, op_unsigned_s;
    logic [31:0] op_addr_s, op_wdata_s;
    logic [1:0]  op_size_s;

    logic [31:0] offset_s;
    logic [IDX_W-1:0] idx_s;
    logic        fault_s, write_s;
    logic [31:0] old_word_s, merged_s, load_s;

    logic [31:0] mem_r [0:DEPTH_WORDS-1];

    logic        resp_valid_r, resp_err_r;
    logic [31:0] resp_rdata_r;

`ifdef DMEM_RANGE_CHECK_EN
    logic        in_range_s;
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
    assign in_range_s = (offset_s < SPAN_BYTES);
`endif

    // With no wait states the access completes on its acceptance edge, so it
    // must act on the live request rather than the captured copy.
    always_comb begin
        if (state_r == IDLE) begin
            op_we_s       = req_we;
            op_addr_s     = req_addr;
            op_size_s     = req_size;
            op_unsigned_s = req_unsigned;
            op_wdata_s    = req_wdata;
        end else begin
            op_we_s       = cap_we_r;
            op_addr_s     = cap_addr_r;
            op_size_s     = cap_size_r;
            op_unsigned_s = cap_unsigned_r;
            op_wdata_s    = cap_wdata_r;
        end
    end

    assign offset_s   = op_addr_s - DM_START;
    assign idx_s      = IDX_W'(offset_s >> 2);
    assign old_word_s = mem_r[idx_s];

    // Fault classification for the access in flight.
    always_comb begin
`ifdef DMEM_RANGE_CHECK_EN
        fault_s = access_fault(op_size_s, op_addr_s[1:0]) || !in_range_s;
`else
        fault_s = access_fault(op_size_s, op_addr_s[1:0]);
`endif
    end

    assign write_s = enter_resp_s && op_we_s && !fault_s;

    dmem_lane_align u_lane_align (
        .old_word      (old_word_s),
        .wdata         (op_wdata_s),
        .size          (op_size_s),
        .addr_lo       (op_addr_s[1:0]),
        .load_unsigned (op_unsigned_s),
        .merged_word   (merged_s),
        .load_data     (load_s)
    );

    // Next-state, wait counter and RESP-entry decode.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        accept_s       = 1'b0;
        enter_resp_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s       = 1'b1;
                    wait_cnt_nxt_s = 4'd0;
                    if (NO_WAIT) begin
                        state_nxt_s  = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s    = RESP;
                    enter_resp_s   = 1'b1;
                    wait_cnt_nxt_s = 4'd0;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 4'd1;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM, request capture and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            wait_cnt_r     <= 4'd0;
            cap_we_r       <= 1'b0;
            cap_addr_r     <= 32'h0000_0000;
            cap_size_r     <= 2'b00;
            cap_unsigned_r <= 1'b0;
            cap_wdata_r    <= 32'h0000_0000;
            resp_valid_r   <= 1'b0;
            resp_rdata_r   <= 32'h0000_0000;
            resp_err_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (accept_s) begin
                cap_we_r       <= req_we;
                cap_addr_r     <= req_addr;
                cap_size_r     <= req_size;
                cap_unsigned_r <= req_unsigned;
                cap_wdata_r    <= req_wdata;
            end
            resp_valid_r <= enter_resp_s;
            if (enter_resp_s) begin
                resp_err_r   <= fault_s;
                resp_rdata_r <= (fault_s || op_we_s) ? 32'h0000_0000 : load_s;
            end
        end
    end

    // Storage: cleared by reset, written on the RESP-entry edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (write_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    assign req_ready  = (state_r == IDLE) && !rst;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios, randomized
// accesses against a byte-array reference model, and a zero-wait instance.
module tb_dmem_responder;

    localparam logic [31:0] DMS       = 32'h1001_0000;
    localparam int          WAITC     = 1;
    localparam int          MEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0;
    logic [31:0] req_addr0 = 32'h0, req_wdata0 = 32'h0;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_mem [0:MEM_BYTES-1];

    always #5 clk = ~clk;

    dmem_responder #(.DM_START(DMS), .DEPTH_WORDS(64), .WAIT_CYCLES(WAITC)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DM_START(DMS), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_addr(req_addr0), .req_size(2'b10),
        .req_unsigned(1'b0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int model_off(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - DMS;
        return int'(off % MEM_BYTES);
    endfunction

    function automatic logic model_fault(input logic [1:0] size, input logic [31:0] addr);
        logic f;
        logic [31:0] off;
        off = addr - DMS;
        f = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`ifdef DMEM_RANGE_CHECK_EN
        if (off >= 32'(MEM_BYTES)) f = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                               input logic uns);
        logic [31:0] val, mask;
        int n, base;
        n    = 1 << size;
        base = model_off(addr);
        val  = 32'h0;
        for (int i = 0; i < n; i++) val = val | (32'(model_mem[base + i]) << (8 * i));
        if (n < 4 && !uns) begin
            mask = (32'd1 << (8 * n)) - 32'd1;
            if (val[8 * n - 1]) val = val | ~mask;
        end
        return val;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
        int n, base;
        n    = 1 << size;
        base = model_off(addr);
        for (int i = 0; i < n; i++) model_mem[base + i] = wd[8 * i +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
    endtask

    // One access on the main instance, checked against the model.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
        logic        exp_f;
        logic [31:0] exp_d;
        int          cyc;
        bit          seen;
        exp_f = model_fault(size, addr);
        exp_d = (!exp_f && !we) ? model_load(size, addr, uns) : 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        check_eq("ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (resp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("resp_seen", 32'(seen), 32'd1);
        rd = 32'h0; er = 1'b0;
        if (seen) begin
            check_eq("latency", 32'(cyc), 32'(WAITC));
            rd = resp_rdata; er = resp_err;
            check_eq("resp_err", 32'(resp_err), 32'(exp_f));
            if (!we || exp_f) check_eq("resp_rdata", resp_rdata, exp_d);
            @(negedge clk);
            check_eq("resp_pulse", 32'(resp_valid), 32'd0);
        end
        if (we && !exp_f) model_store(size, addr, wd);
    endtask

    task automatic set0(input int j);
        req_we0    = (j < 4);
        req_addr0  = DMS + 32'(4 * (j % 4));
        req_wdata0 = 32'h100 + 32'(j);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n, acc, nresp;
        bit          pend;
        logic [3:0]  pat;

        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_ready0", 32'(req_ready0), 32'd0);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(req_ready), 32'd1);
        check_eq("post_rst_rdata", resp_rdata, 32'h0);
        check_eq("post_rst_err", 32'(resp_err), 32'd0);

        run_access(1'b1, 32'h1001_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, er);
        check_eq("word_store_err", 32'(er), 32'd0);
        run_access(1'b0, 32'h1001_0004, 2'b10, 1'b0, 32'h0, rd, er);
        check_eq("word_load", rd, 32'hDEAD_BEEF);

        run_access(1'b1, 32'h1001_0009, 2'b00, 1'b0, 32'h80, rd, er);
        run_access(1'b0, 32'h1001_0009, 2'b00, 1'b0, 32'h0, rd, er);
        check_eq("byte_signed", rd, 32'hFFFF_FF80);
        run_access(1'b0, 32'h1001_0009, 2'b00, 1'b1, 32'h0, rd, er);
        check_eq("byte_unsigned", rd, 32'h0000_0080);
        run_access(1'b0, 32'h1001_0008, 2'b10, 1'b0, 32'h0, rd, er);
        check_eq("byte_lane_word", rd, 32'h0000_8000);

        run_access(1'b1, 32'h1001_0000, 2'b10, 1'b0, 32'h8001_1234, rd, er);
        run_access(1'b0, 32'h1001_0002, 2'b01, 1'b0, 32'h0, rd, er);
        check_eq("half_signed", rd, 32'hFFFF_8001);
        run_access(1'b0, 32'h1001_0002, 2'b01, 1'b1, 32'h0, rd, er);
        check_eq("half_unsigned", rd, 32'h0000_8001);
        run_access(1'b0, 32'h1001_0001, 2'b01, 1'b0, 32'h0, rd, er);
        check_eq("half_misalign_err", 32'(er), 32'd1);
        check_eq("half_misalign_rd", rd, 32'h0);

        // Reset during the WAIT cycle of a store: abandoned, memory cleared.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1001_000C; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        model_clear();
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        check_eq("abandoned_no_resp", 32'(n), 32'd0);
        run_access(1'b0, 32'h1001_000C, 2'b10, 1'b0, 32'h0, rd, er);
        check_eq("abandoned_no_write", rd, 32'h0);

        run_access(1'b1, 32'h1001_0100, 2'b10, 1'b0, 32'h1234_5678, rd, er);
        run_access(1'b0, 32'h1001_0000, 2'b10, 1'b0, 32'h0, rd, er);
`ifdef DMEM_RANGE_CHECK_EN
        check_eq("range_wrap_load", rd, 32'h0);
`else
        check_eq("range_wrap_load", rd, 32'h1234_5678);
`endif

        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = DMS + 32'($urandom_range(0, 319)) - 32'd32;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            run_access(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom(), rd, er);
        end

        // Zero-wait instance with req_valid held high throughout.
        acc = 0; nresp = 0; pend = 1'b0; pat = 4'b0000;
        @(negedge clk);
        req_valid0 = 1'b1;
        set0(0);
        for (int c = 0; c < 40 && nresp < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (pend) begin
                acc++;
                pend = 1'b0;
                if (acc < 8) set0(acc);
                else req_valid0 = 1'b0;
            end
            if (resp_valid0) begin
                if (nresp >= 4) check_eq("zw_load", resp_rdata0, 32'h100 + 32'(nresp - 4));
                check_eq("zw_err", 32'(resp_err0), 32'd0);
                nresp++;
            end
            if (c < 4) pat[3 - c] = req_ready0;
            if (req_ready0 && req_valid0) pend = 1'b1;
        end
        req_valid0 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid0) nresp++;
        end
        check_eq("zw_ready_pattern", 32'(pat), 32'hA);
        check_eq("zw_accepted", 32'(acc), 32'd8);
        check_eq("zw_responses", 32'(nresp), 32'd8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
